// File: rtl/traceback_block_if.sv
// traceback_block_if: port bundle for traceback_block.
// Carries the writer status inputs, the survivor-row read bus, the decoded-word
// valid/ready handshake and the status flags. The optional statistics counters
// are present only when TRACEBACK_STATS_EN is defined.
// master = traceback unit side, slave = surrounding logic (ACS/memory/consumer).
interface traceback_block_if #(
  parameter int M = 6,
  parameter int D = 32,
  parameter int L = 8
);
  localparam int N      = D + L;
  localparam int TIME_W = $clog2(N);

  logic [TIME_W-1:0] wr_ptr;
  logic [M-1:0]      s_end;
  logic              flush;
  logic              tb_rd_en;
  logic [TIME_W-1:0] tb_time;
  logic [(1<<M)-1:0] tb_row;
  logic [L-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              busy;
`ifdef TRACEBACK_STATS_EN
  logic [15:0]       words_out;
  logic [15:0]       drops_out;
`endif

  modport master (
    input  wr_ptr, s_end, flush, tb_row, out_ready,
`ifdef TRACEBACK_STATS_EN
    output words_out, drops_out,
`endif
    output tb_rd_en, tb_time, out_data, out_valid, overrun, busy
  );

  modport slave (
    output wr_ptr, s_end, flush, tb_row, out_ready,
`ifdef TRACEBACK_STATS_EN
    input  words_out, drops_out,
`endif
    input  tb_rd_en, tb_time, out_data, out_valid, overrun, busy
  );
endinterface

// File: rtl/traceback_block.sv
// traceback_block: block-mode Viterbi traceback.
// Each trace walks D convergence columns then L decode columns backwards from
// the requested start column, one survivor row per clock, and presents the L
// decoded bits as one word (bit 0 = oldest) on a valid/ready handshake.
// One pending request slot; a request arriving with the slot full is dropped
// and flagged on the sticky overrun output.
// Optional macro TRACEBACK_STATS_EN adds saturating words_out/drops_out counters.
module traceback_block #(
  parameter int M = 6,
  parameter int D = 32,
  parameter int L = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  traceback_block_if.master   bus
);
  localparam int N      = D + L;
  localparam int TIME_W = $clog2(N);
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, TRACE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [TIME_W-1:0]  wr_ptr_q;
  logic               flush_q;
  logic [CNT_W-1:0]   fill_q;
  logic [CNT_W-1:0]   adv_cnt_q;
  logic               advance, flush_rise, norm_req, req, drop, to_slot;
  logic [M-1:0]       req_state;
  logic               pend_vld_q;
  logic [TIME_W-1:0]  pend_col_q;
  logic [M-1:0]       pend_state_q;
  logic               start;
  logic [TIME_W-1:0]  start_col;
  logic [M-1:0]       start_state;
  logic               overrun_q;
  logic               rd_en_p0;
  logic [TIME_W-1:0]  rd_addr_p0;
  logic [CNT_W-1:0]   iss_cnt_p0;
  logic               vld_p1;
  logic [CNT_W-1:0]   step_p1;
  logic [M-1:0]       path_p1, path_nxt;
  logic [L-1:0]       word_p1;
  logic               bit_p1, last_p1, handshake;

  function automatic logic [CNT_W-1:0] sat_inc_fill(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(N)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TIME_W-1:0] dec_wrap(input logic [TIME_W-1:0] a);
    return (a == '0) ? TIME_W'(N - 1) : a - TIME_W'(1);
  endfunction

  // Request detection: column advances, flush edges, warm-up gating.
  assign advance    = (bus.wr_ptr != wr_ptr_q);
  assign flush_rise = bus.flush & ~flush_q;
  assign norm_req   = advance && (adv_cnt_q == CNT_W'(L - 1)) &&
                      ((fill_q == CNT_W'(N)) || (fill_q == CNT_W'(N - 1)));
  assign req        = norm_req | flush_rise;
  assign req_state  = flush_rise ? '0 : bus.s_end;

  // A queued request always wins over a fresh one when the FSM is idle.
  assign start       = (state_q == IDLE) && (pend_vld_q || req);
  assign start_col   = pend_vld_q ? pend_col_q : bus.wr_ptr;
  assign start_state = pend_vld_q ? pend_state_q : req_state;
  assign to_slot     = req && ((state_q != IDLE) ? !pend_vld_q : pend_vld_q);
  assign drop        = req && (state_q != IDLE) && pend_vld_q;

  assign rd_en_p0  = (state_q == TRACE) && (iss_cnt_p0 != CNT_W'(N));
  assign bit_p1    = bus.tb_row[path_p1];
  assign last_p1   = vld_p1 && (step_p1 == CNT_W'(N - 1));
  assign handshake = (state_q == EMIT) && bus.out_ready;

  generate
    if (M == 1) begin : g_path_m1
      assign path_nxt = bit_p1;
    end else begin : g_path_mn
      assign path_nxt = {bit_p1, path_p1[M-1:1]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: idle -> walk columns -> hold word until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)         state_d = TRACE;
      TRACE:   if (last_p1)       state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Writer tracking: edge detectors, warm-up fill level and decode phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      flush_q   <= 1'b0;
      fill_q    <= '0;
      adv_cnt_q <= '0;
    end else begin
      wr_ptr_q <= bus.wr_ptr;
      flush_q  <= bus.flush;
      if (advance) fill_q <= sat_inc_fill(fill_q);
      if (flush_rise)
        adv_cnt_q <= '0;
      else if (advance)
        adv_cnt_q <= (adv_cnt_q == CNT_W'(L - 1)) ? '0 : adv_cnt_q + CNT_W'(1);
    end
  end

  // Pending slot occupancy and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (to_slot)                  pend_vld_q <= 1'b1;
      else if (start && pend_vld_q) pend_vld_q <= 1'b0;
      if (drop)                     overrun_q  <= 1'b1;
    end
  end

  // Pending slot payload.
  always_ff @(posedge clk) begin
    if (to_slot) begin
      pend_col_q   <= bus.wr_ptr;
      pend_state_q <= req_state;
    end
  end

  // ---- p0: survivor row address issue ----
  // Walks addresses backwards from the start column, wrapping 0 -> N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_p0 <= '0;
      iss_cnt_p0 <= '0;
    end else if (start) begin
      rd_addr_p0 <= start_col;
      iss_cnt_p0 <= '0;
    end else if (rd_en_p0) begin
      rd_addr_p0 <= dec_wrap(rd_addr_p0);
      iss_cnt_p0 <= iss_cnt_p0 + CNT_W'(1);
    end
  end

  // ---- p1: row returned, survivor bit selected, state updated ----
  // Step control: row-valid flag and step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      step_p1 <= '0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (start) begin
        step_p1 <= '0;
      end else if (vld_p1) begin
        step_p1 <= step_p1 + CNT_W'(1);
        // Later steps are older bits, so shifting up leaves the oldest at bit 0.
        if (step_p1 >= CNT_W'(D)) word_p1 <= (word_p1 << 1) | L'(bit_p1);
      end
    end
  end

  // Traceback path state.
  always_ff @(posedge clk) begin
    if (start)       path_p1 <= start_state;
    else if (vld_p1) path_p1 <= path_nxt;
  end

`ifdef TRACEBACK_STATS_EN
  logic [15:0] words_q, drops_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counts of accepted words and dropped requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      drops_q <= '0;
    end else begin
      if (handshake) words_q <= sat_inc16(words_q);
      if (drop)      drops_q <= sat_inc16(drops_q);
    end
  end

  assign bus.words_out = words_q;
  assign bus.drops_out = drops_q;
`endif

  assign bus.tb_rd_en  = rd_en_p0;
  assign bus.tb_time   = rd_addr_p0;
  assign bus.out_data  = word_p1;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_traceback_block.sv
// tb_traceback_block: directed bench for traceback_block with M=2, D=4, L=2.
// A small registered survivor memory answers read strobes one cycle later.
module tb_traceback_block;
  localparam int M = 2;
  localparam int D = 4;
  localparam int L = 2;
  localparam int N = D + L;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errs  = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traceback_block_if #(.M(M), .D(D), .L(L)) bus ();

  traceback_block #(.M(M), .D(D), .L(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] mem [0:N-1];

  // Registered survivor memory.
  always @(posedge clk) begin
    if (bus.tb_rd_en) bus.tb_row <= mem[bus.tb_time];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the first issue cycle; ends in the first cycle out_valid is high.
  task automatic trace_check(input string tag, input int t0, input logic [1:0] expd);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_rd_en"}, 32'(bus.tb_rd_en), 32'd1);
      chk({tag, "_time"}, 32'(bus.tb_time), 32'((t0 - k + N) % N));
      step();
    end
    chk({tag, "_gap"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(expd));
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_vdrop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.wr_ptr    = 3'd0;
    bus.s_end     = 2'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 4'hF;

    // Reset state
    step();
    step();
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovr",   32'(bus.overrun),   32'd0);
    chk("rst_rd_en", 32'(bus.tb_rd_en),  32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_time",  32'(bus.tb_time),   32'd0);
    rst_n = 1'b1;
    step();

    // Warm-up: five advances leave the unit idle, the sixth starts a trace.
    // All-ones rows from state 0 walk 0,2,3,3,3,3 and decode 2'b11.
    for (int i = 1; i <= 5; i++) begin
      bus.wr_ptr = 3'(i);
      step();
      chk("warm_idle", 32'(bus.busy), 32'd0);
    end
    bus.wr_ptr = 3'd0;
    step();
    chk("warm_busy", 32'(bus.busy), 32'd1);
    trace_check("warm", 0, 2'b11);
    accept("warm");

    // Wrap: start column 1, state 1, patterned rows -> 2'b01.
    mem[0] = 4'b0000; mem[1] = 4'b1010; mem[2] = 4'b0010;
    mem[3] = 4'b0111; mem[4] = 4'b0100; mem[5] = 4'b0010;
    bus.s_end  = 2'd1;
    bus.wr_ptr = 3'd3;
    step();
    chk("wrap_pre_idle", 32'(bus.busy), 32'd0);
    bus.wr_ptr = 3'd1;
    step();
    chk("wrap_busy", 32'(bus.busy), 32'd1);
    trace_check("wrap", 1, 2'b01);
    accept("wrap");

    // Flush: s_end=3 ignored, trace from state 0 at column 2 -> 2'b01.
    bus.wr_ptr = 3'd2;
    step();
    chk("flush_pre_idle", 32'(bus.busy), 32'd0);
    bus.s_end = 2'd3;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd1);
    trace_check("flush", 2, 2'b01);
    accept("flush");
    bus.wr_ptr = 3'd3;
    step();
    chk("flush_advcnt", 32'(bus.busy), 32'd0);

    // Backpressure: trace from column 4, state 3 -> 2'b01, held 20 cycles.
    bus.wr_ptr = 3'd4;
    step();
    chk("bp_busy", 32'(bus.busy), 32'd1);
    trace_check("bp", 4, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) bus.wr_ptr = 3'd5;
      if (i == 4) bus.wr_ptr = 3'd0;
      if (i == 6) begin
        chk("bp_ovr_clear", 32'(bus.overrun), 32'd0);
        bus.wr_ptr = 3'd1;
      end
      if (i == 8) begin
        bus.wr_ptr = 3'd2;
        bus.s_end  = 2'd0;
      end
      step();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data",  32'(bus.out_data),  32'd1);
    end
    chk("bp_ovr_set", 32'(bus.overrun), 32'd1);
    accept("bp");
    step();
    chk("pend_busy", 32'(bus.busy), 32'd1);
    trace_check("pend", 0, 2'b10);
    accept("pend");
`ifdef TRACEBACK_STATS_EN
    chk("stats_words", 32'(bus.words_out), 32'd5);
    chk("stats_drops", 32'(bus.drops_out), 32'd1);
`endif

    // Reset mid-trace aborts the word, the flags and the fill level.
    bus.wr_ptr = 3'd3;
    step();
    chk("rst2_pre_idle", 32'(bus.busy), 32'd0);
    bus.wr_ptr = 3'd4;
    step();
    chk("rst2_busy", 32'(bus.busy), 32'd1);
    step();
    step();
    step();
    rst_n = 1'b0;
    bus.wr_ptr = 3'd0;
    #1;
    chk("rst2_busy0",  32'(bus.busy),      32'd0);
    chk("rst2_valid0", 32'(bus.out_valid), 32'd0);
    chk("rst2_ovr0",   32'(bus.overrun),   32'd0);
    chk("rst2_rd_en0", 32'(bus.tb_rd_en),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      bus.wr_ptr = 3'(i);
      step();
      chk("rst2_refill_idle", 32'(bus.busy), 32'd0);
    end
    bus.wr_ptr = 3'd0;
    step();
    chk("rst2_refill_busy", 32'(bus.busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
